// File: rtl/collision_arbiter.sv
// rtl/collision_arbiter.sv - per-frame pair collision detector with first-hit event FIFO
// Optional COLLISION_COORD_EN adds pixel coordinate capture per event.
module collision_arbiter #(
  parameter int NUM_OBJ = 4,
  parameter logic [NUM_OBJ*(NUM_OBJ-1)/2-1:0] PAIR_MASK = '1,
  parameter int DEPTH = 8,
  parameter int HIT_CNT_W = 8,
  localparam int P = NUM_OBJ*(NUM_OBJ-1)/2,
  localparam int PW = (P > 1) ? $clog2(P) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic [NUM_OBJ-1:0]   draw_req,
`ifdef COLLISION_COORD_EN
  input  logic [10:0]          pixelX,
  input  logic [10:0]          pixelY,
  output logic [10:0]          ev_x,
  output logic [10:0]          ev_y,
`endif
  output logic [P-1:0]         hit_pulse,
  output logic [P-1:0]         frame_hits,
  output logic [HIT_CNT_W-1:0] hit_count,
  output logic                 ev_valid,
  output logic [PW-1:0]        ev_pair,
  input  logic                 ev_ready,
  output logic                 ev_overflow
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [PW-1:0] pair;
`ifdef COLLISION_COORD_EN
    logic [10:0]   x;
    logic [10:0]   y;
`endif
  } ev_t;

  logic [P-1:0]          hit_now, first, push_oh;
  logic [P-1:0]          seen_q, seen_d, pending_q, pending_d;
  logic [P-1:0]          hit_pulse_q, frame_hits_q, frame_hits_d;
  logic [HIT_CNT_W-1:0]  cnt_q, cnt_d, hit_count_q, hit_count_d, base;
  logic [HIT_CNT_W+5:0]  sum;
  logic [5:0]            pop_n;
  logic                  overflow_q, overflow_d;
  logic [AW:0]           wr_q, wr_d, rd_q, rd_d;
  ev_t                   mem_q [DEPTH];
  ev_t                   mem_d [DEPTH];
  ev_t                   last_q, last_d, head, push_ev;
  logic                  empty, full, pop, push;
  logic [PW-1:0]         sel;
`ifdef COLLISION_COORD_EN
  logic [10:0]           x_q [P];
  logic [10:0]           x_d [P];
  logic [10:0]           y_q [P];
  logic [10:0]           y_d [P];
`endif

  // Pair index is lexicographic over i<j.
  always_comb begin
    hit_now = '0;
    for (int i = 0; i < NUM_OBJ; i++)
      for (int j = i + 1; j < NUM_OBJ; j++)
        hit_now[i*NUM_OBJ - (i*(i+1))/2 + j - i - 1] =
          draw_req[i] & draw_req[j] & PAIR_MASK[i*NUM_OBJ - (i*(i+1))/2 + j - i - 1];
  end

  always_comb begin
    first  = hit_now & (~seen_q | {P{startOfFrame}});
    seen_d = startOfFrame ? hit_now : (seen_q | hit_now);
    pop_n  = '0;
    for (int p = 0; p < P; p++) pop_n = pop_n + 6'(first[p]);
    base   = startOfFrame ? '0 : cnt_q;
    sum    = {6'd0, base} + {{HIT_CNT_W{1'b0}}, pop_n};
    cnt_d  = (sum > {6'd0, {HIT_CNT_W{1'b1}}}) ? {HIT_CNT_W{1'b1}} : sum[HIT_CNT_W-1:0];
    frame_hits_d = startOfFrame ? seen_q : frame_hits_q;
    hit_count_d  = startOfFrame ? cnt_q : hit_count_q;
  end

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  always_comb begin
    empty = (wr_q == rd_q);
    full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    head  = mem_q[rd_q[AW-1:0]];
    pop   = ~empty & ev_ready;
    push  = (|pending_q) & (~full | pop);
    sel   = '0;
    for (int p = P - 1; p >= 0; p--)
      if (pending_q[p]) sel = PW'(p);
    push_oh = push ? (P'(1) << sel) : '0;
    push_ev = '0;
    push_ev.pair = sel;
`ifdef COLLISION_COORD_EN
    push_ev.x = first[sel] ? pixelX : x_q[sel];
    push_ev.y = first[sel] ? pixelY : y_q[sel];
`endif
    // A repeat first-hit on a still-pending pair is absorbed into that entry.
    pending_d  = (pending_q | first) & ~push_oh;
    overflow_d = overflow_q | (|(first & pending_q));
    mem_d = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = push_ev;
    wr_d   = wr_q + (AW+1)'(push);
    rd_d   = rd_q + (AW+1)'(pop);
    last_d = empty ? last_q : head;
  end

`ifdef COLLISION_COORD_EN
  always_comb begin
    for (int p = 0; p < P; p++) begin
      x_d[p] = first[p] ? pixelX : x_q[p];
      y_d[p] = first[p] ? pixelY : y_q[p];
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_q       <= '0;
      pending_q    <= '0;
      hit_pulse_q  <= '0;
      frame_hits_q <= '0;
      cnt_q        <= '0;
      hit_count_q  <= '0;
      overflow_q   <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      last_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef COLLISION_COORD_EN
      for (int p = 0; p < P; p++) begin
        x_q[p] <= '0;
        y_q[p] <= '0;
      end
`endif
    end else begin
      seen_q       <= seen_d;
      pending_q    <= pending_d;
      hit_pulse_q  <= first;
      frame_hits_q <= frame_hits_d;
      cnt_q        <= cnt_d;
      hit_count_q  <= hit_count_d;
      overflow_q   <= overflow_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      last_q       <= last_d;
      mem_q        <= mem_d;
`ifdef COLLISION_COORD_EN
      x_q          <= x_d;
      y_q          <= y_d;
`endif
    end
  end

  assign hit_pulse   = hit_pulse_q;
  assign frame_hits  = frame_hits_q;
  assign hit_count   = hit_count_q;
  assign ev_valid    = ~empty;
  assign ev_pair     = empty ? last_q.pair : head.pair;
  assign ev_overflow = overflow_q;
`ifdef COLLISION_COORD_EN
  assign ev_x = empty ? last_q.x : head.x;
  assign ev_y = empty ? last_q.y : head.y;
`endif

endmodule

// File: tb/tb_collision_arbiter.sv
// tb/tb_collision_arbiter.sv - directed vector bench for collision_arbiter
module tb_collision_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sof = 1'b0;
  logic [3:0] dr = '0;
  logic rdy = 1'b0;

  logic [5:0] hp, fh, m_hp, m_fh, d_hp, d_fh;
  logic [7:0] hc, m_hc;
  logic [0:0] d_hc;
  logic v, m_v, d_v, ov, m_ov, d_ov;
  logic [2:0] pr, m_pr, d_pr;
`ifdef COLLISION_COORD_EN
  logic [10:0] px = '0, py = '0;
  logic [10:0] ex, ey, m_ex, m_ey, d_ex, d_ey;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  collision_arbiter u_dut (
`ifdef COLLISION_COORD_EN
    .pixelX(px), .pixelY(py), .ev_x(ex), .ev_y(ey),
`endif
    .clk(clk), .reset(rst), .startOfFrame(sof), .draw_req(dr),
    .hit_pulse(hp), .frame_hits(fh), .hit_count(hc), .ev_valid(v),
    .ev_pair(pr), .ev_ready(rdy), .ev_overflow(ov)
  );

  collision_arbiter #(.PAIR_MASK(6'b111110)) u_msk (
`ifdef COLLISION_COORD_EN
    .pixelX(px), .pixelY(py), .ev_x(m_ex), .ev_y(m_ey),
`endif
    .clk(clk), .reset(rst), .startOfFrame(sof), .draw_req(dr),
    .hit_pulse(m_hp), .frame_hits(m_fh), .hit_count(m_hc), .ev_valid(m_v),
    .ev_pair(m_pr), .ev_ready(rdy), .ev_overflow(m_ov)
  );

  collision_arbiter #(.DEPTH(2), .HIT_CNT_W(1)) u_d2 (
`ifdef COLLISION_COORD_EN
    .pixelX(px), .pixelY(py), .ev_x(d_ex), .ev_y(d_ey),
`endif
    .clk(clk), .reset(rst), .startOfFrame(sof), .draw_req(dr),
    .hit_pulse(d_hp), .frame_hits(d_fh), .hit_count(d_hc), .ev_valid(d_v),
    .ev_pair(d_pr), .ev_ready(rdy), .ev_overflow(d_ov)
  );

  typedef struct {
    logic       sof;
    logic [3:0] dr;
    logic       rdy;
    logic [5:0] hp;
    logic       v;
    logic [2:0] pr;
    logic [5:0] fh;
    logic [7:0] hc;
    logic [5:0] m_hp;
    logic       m_v;
    logic [7:0] m_hc;
    logic       d_hc;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step(input logic s, input logic [3:0] d, input logic r);
    @(negedge clk);
    sof = s;
    dr  = d;
    rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sof = 1'b0;
    dr  = '0;
    rdy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //          sof dr       rdy hp         v  pr    fh         hc    m_hp       m_v m_hc  d_hc
    tbl[0]  = '{1, 4'b0000, 1, 6'b000000, 0, 3'd0, 6'b000000, 8'd0, 6'b000000, 0, 8'd0, 0};
    tbl[1]  = '{0, 4'b0011, 1, 6'b000001, 0, 3'd0, 6'b000000, 8'd0, 6'b000000, 0, 8'd0, 0};
    tbl[2]  = '{0, 4'b0011, 1, 6'b000000, 1, 3'd0, 6'b000000, 8'd0, 6'b000000, 0, 8'd0, 0};
    tbl[3]  = '{0, 4'b0011, 1, 6'b000000, 0, 3'd0, 6'b000000, 8'd0, 6'b000000, 0, 8'd0, 0};
    tbl[4]  = '{0, 4'b0011, 1, 6'b000000, 0, 3'd0, 6'b000000, 8'd0, 6'b000000, 0, 8'd0, 0};
    tbl[5]  = '{0, 4'b0011, 1, 6'b000000, 0, 3'd0, 6'b000000, 8'd0, 6'b000000, 0, 8'd0, 0};
    tbl[6]  = '{1, 4'b0000, 1, 6'b000000, 0, 3'd0, 6'b000001, 8'd1, 6'b000000, 0, 8'd0, 1};
    tbl[7]  = '{0, 4'b0111, 1, 6'b001011, 0, 3'd0, 6'b000001, 8'd1, 6'b001010, 0, 8'd0, 1};
    tbl[8]  = '{0, 4'b0000, 1, 6'b000000, 1, 3'd0, 6'b000001, 8'd1, 6'b000000, 1, 8'd0, 1};
    tbl[9]  = '{0, 4'b0000, 1, 6'b000000, 1, 3'd1, 6'b000001, 8'd1, 6'b000000, 1, 8'd0, 1};
    tbl[10] = '{0, 4'b0000, 1, 6'b000000, 1, 3'd3, 6'b000001, 8'd1, 6'b000000, 0, 8'd0, 1};
    tbl[11] = '{0, 4'b0000, 1, 6'b000000, 0, 3'd3, 6'b000001, 8'd1, 6'b000000, 0, 8'd0, 1};
    tbl[12] = '{1, 4'b0000, 1, 6'b000000, 0, 3'd3, 6'b001011, 8'd3, 6'b000000, 0, 8'd2, 1};

    do_reset();
    #1;
    chk("reset_hit_pulse", 32'(hp), 32'd0);
    chk("reset_ev_valid", 32'(v), 32'd0);
    chk("reset_hit_count", 32'(hc), 32'd0);
    chk("reset_overflow", 32'(ov), 32'd0);

    for (int k = 0; k < 13; k++) begin
      step(tbl[k].sof, tbl[k].dr, tbl[k].rdy);
      chk($sformatf("v%0d_hit_pulse", k), 32'(hp), 32'(tbl[k].hp));
      chk($sformatf("v%0d_ev_valid", k), 32'(v), 32'(tbl[k].v));
      chk($sformatf("v%0d_ev_pair", k), 32'(pr), 32'(tbl[k].pr));
      chk($sformatf("v%0d_frame_hits", k), 32'(fh), 32'(tbl[k].fh));
      chk($sformatf("v%0d_hit_count", k), 32'(hc), 32'(tbl[k].hc));
      chk($sformatf("v%0d_mask_pulse", k), 32'(m_hp), 32'(tbl[k].m_hp));
      chk($sformatf("v%0d_mask_valid", k), 32'(m_v), 32'(tbl[k].m_v));
      chk($sformatf("v%0d_mask_count", k), 32'(m_hc), 32'(tbl[k].m_hc));
      chk($sformatf("v%0d_sat_count", k), 32'(d_hc), 32'(tbl[k].d_hc));
    end
    chk("table_overflow", 32'(ov), 32'd0);

    // Two-entry FIFO fills; pair 2 waits in pending until space opens.
    do_reset();
    step(0, 4'b0011, 0); chk("d2_a_valid", 32'(d_v), 32'd0);
    step(0, 4'b0101, 0); chk("d2_b_valid", 32'(d_v), 32'd1); chk("d2_b_pair", 32'(d_pr), 32'd0);
    step(0, 4'b1001, 0); chk("d2_c_pair", 32'(d_pr), 32'd0);
    step(0, 4'b0000, 0); chk("d2_full_valid", 32'(d_v), 32'd1);
    step(0, 4'b0000, 0); chk("d2_full_pair", 32'(d_pr), 32'd0);
    step(0, 4'b0000, 1); chk("d2_pop1_pair", 32'(d_pr), 32'd1);
    step(0, 4'b0000, 1); chk("d2_pop2_pair", 32'(d_pr), 32'd2); chk("d2_pop2_valid", 32'(d_v), 32'd1);
    step(0, 4'b0000, 1); chk("d2_empty_valid", 32'(d_v), 32'd0); chk("d2_hold_pair", 32'(d_pr), 32'd2);
    step(0, 4'b0000, 1); chk("d2_still_empty", 32'(d_v), 32'd0);
    chk("d2_overflow", 32'(d_ov), 32'd0);

    // Back-to-back one-cycle frames: second first-hit merges into the pending one.
    do_reset();
    step(1, 4'b0011, 0);
    chk("ov_a_pulse", 32'(hp), 32'd1); chk("ov_a_flag", 32'(ov), 32'd0); chk("ov_a_valid", 32'(v), 32'd0);
    step(1, 4'b0011, 0);
    chk("ov_b_pulse", 32'(hp), 32'd1); chk("ov_b_flag", 32'(ov), 32'd1);
    chk("ov_b_valid", 32'(v), 32'd1); chk("ov_b_pair", 32'(pr), 32'd0); chk("ov_b_count", 32'(hc), 32'd1);
    step(0, 4'b0000, 1); chk("ov_single_event", 32'(v), 32'd0);
    step(0, 4'b0000, 1); chk("ov_no_second", 32'(v), 32'd0); chk("ov_sticky", 32'(ov), 32'd1);

    // Reset mid-burst discards queued and pending events.
    step(1, 4'b0111, 0); chk("rb_pulse", 32'(hp), 32'h0b); chk("rb_frame_hits", 32'(fh), 32'd1);
    step(0, 4'b0000, 0); chk("rb_valid", 32'(v), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    sof = 1'b0;
    dr  = '0;
    #1;
    chk("rst_async_valid", 32'(v), 32'd0);
    chk("rst_async_pulse", 32'(hp), 32'd0);
    chk("rst_async_pair", 32'(pr), 32'd0);
    chk("rst_async_fh", 32'(fh), 32'd0);
    chk("rst_async_hc", 32'(hc), 32'd0);
    chk("rst_async_ov", 32'(ov), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(0, 4'b0000, 1);
      chk($sformatf("post_rst_valid%0d", k), 32'(v), 32'd0);
    end

`ifdef COLLISION_COORD_EN
    @(negedge clk);
    px = 11'd320;
    py = 11'd240;
    step(0, 4'b0011, 0);
    px = 11'd0;
    py = 11'd0;
    step(0, 4'b0000, 0);
    chk("coord_valid", 32'(v), 32'd1);
    chk("coord_x", 32'(ex), 32'd320);
    chk("coord_y", 32'(ey), 32'd240);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/collision_arbiter.md
# collision_arbiter

Parametrised per-frame collision detector for the VGA billiard pipeline. It sits between the object drawing-request outputs (balls, walls, holes) and the physics/score logic. It watches NUM_OBJ drawing requests every pixel and generates one hit pulse per enabled object pair per frame. It queues each pair's first hit into an event FIFO so downstream logic can consume collisions one at a time.

## Interface
- NUM_OBJ, default 4: number of drawing-request inputs; legal range 2..8.
- P (derived, not overridable): NUM_OBJ*(NUM_OBJ-1)/2, the pair count.
- PAIR_MASK, default all ones (width P): bit p enables pair p.
- DEPTH, default 8: event FIFO depth; must be a power of two, minimum 2.
- HIT_CNT_W, default 8: width of the per-frame hit counter.
- Pair index order is lexicographic over i<j. For NUM_OBJ=4: (0,1)=0, (0,2)=1, (0,3)=2, (1,2)=3, (1,3)=4, (2,3)=5.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at frame start.
- draw_req  in  NUM_OBJ  drawing request per object for the current pixel.
- hit_pulse  out  P  registered one-cycle pulse on a pair's first hit in the frame.
- frame_hits  out  P  pairs hit during the previous frame; updated at startOfFrame.
- hit_count  out  HIT_CNT_W  first-hits in the previous frame, saturating.
- ev_valid  out  1  FIFO head is valid.
- ev_pair  out  clog2(P)  pair index at the FIFO head.
- ev_ready  in  1  consumer accepts the head.
- ev_overflow  out  1  sticky flag: a first hit merged into an already-pending pair.

## Operation
- Combinational term: hit_now[p] = draw_req[i] & draw_req[j] & PAIR_MASK[p].
- seen[p] register:
  - On startOfFrame, seen is cleared. A hit in that same cycle counts as the first hit of the new frame, so it sets seen and pulses.
  - Otherwise, seen[p] is set on hit_now[p].
- first[p] = hit_now[p] & (~seen[p] | startOfFrame). The hit_pulse register loads first every cycle.
- hit counter:
  - On startOfFrame, frame_hits <= seen and hit_count <= running counter.
  - The running counter then restarts at popcount(first) for that cycle.
  - On other cycles it adds popcount(first), saturating at 2^HIT_CNT_W-1.
- pending[p] is set on first[p]. Each cycle, if the FIFO can accept, the lowest-index pending bit is pushed and cleared. At most one push per cycle.
- If first[p] occurs while pending[p] is already set, the events merge and ev_overflow is set. ev_overflow clears only on reset.
- FIFO behaviour:
  - Full: no push; pending holds. No event is ever dropped.
  - Push is allowed when full if a pop occurs in the same cycle.
  - Empty: ev_valid=0 and ev_pair holds its last value.
- Reset values: all outputs 0; seen, pending and FIFO pointers cleared. Reset mid-frame discards pending and queued events.

## Timing
- Cycle C: hit_now asserted. Edge C+1: hit_pulse, seen and pending are set. Edge C+2: entry written; ev_valid high from C+2 when the FIFO was empty.
- Pop happens on the edge where ev_valid & ev_ready. The next entry is visible the following cycle.
- k simultaneous first-hits enter the FIFO on k consecutive cycles, lowest index first.
- frame_hits and hit_count change only on the edge after startOfFrame.

## Configuration
- COLLISION_COORD_EN defined:
  - Adds inputs pixelX and pixelY (11 bits each) and outputs ev_x and ev_y.
  - On first[p], the block latches the current pixelX/pixelY per pair. The coordinate is carried with the pair into the FIFO and presented with ev_pair.
  - If a later hit merges into a still-pending pair, the coordinate is overwritten with the latest hit.
- Undefined: these ports and storage are absent; all other behaviour is identical.

## Test plan
- NUM_OBJ=4, draw_req=4'b0011 for 5 cycles → hit_pulse[0] exactly once at C+1; ev_valid at C+2 with ev_pair=0; after startOfFrame, frame_hits=6'b000001 and hit_count=1.
- draw_req=4'b0111 in one cycle, ev_ready=1 → hit_pulse=6'b001011; ev_pair sequence 0, 1, 3 on consecutive cycles; hit_count=3 next frame.
- PAIR_MASK=6'b111110, draw_req=4'b0011 → no pulse, no event, hit_count=0.
- DEPTH=2, ev_ready=0, hits on pairs 0, 1, 2 → FIFO holds 0 and 1 while pending[2] stays; raise ev_ready → 0, 1, 2 delivered; ev_overflow=0.
- Hit on pair 0 coincident with startOfFrame, then again next frame with ev_ready=0 → second first-hit merges and ev_overflow=1.
- Assert reset mid-burst with 3 pending → all outputs 0 within the reset; no event after release. With COLLISION_COORD_EN, a hit at (320,240) yields ev_x=320, ev_y=240.
